yuu_apb_mem_slave: RTL and testbench
====================================

# yuu_apb_mem_slave

Synthesizable APB3/APB4 completer with an internal word-addressed memory and programmable wait-state insertion. It is the RTL responder that the APB master agent drives in self-checking loopback benches, and it exercises pready stalls, pslverr and pstrb handling. It is compiled with `yuu_common_pkg` and uses its `boolean` type for feature switches.

## Interface
- ADDR_WIDTH, 16: paddr width in bits.
- DATA_WIDTH, 32: data width in bits. Legal values are 8, 16 and 32.
- DEPTH, 64: number of DATA_WIDTH words in the memory.
- USE_PSTRB, True (boolean): when True, pstrb gates byte lanes. When False, every write updates all lanes.
- ERR_EN, True (boolean): when True, out-of-range and misaligned accesses return pslverr=1. When False, pslverr is tied to 0 and the address index wraps modulo DEPTH.

Ports:
- pclk  in  1  clock. All logic is rising-edge.
- presetn  in  1  asynchronous active-low reset.
- psel  in  1  select.
- penable  in  1  access phase.
- pwrite  in  1  1=write, 0=read.
- paddr  in  ADDR_WIDTH  byte address.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  DATA_WIDTH/8  byte-lane strobes.
- wait_cfg  in  4  wait states for the next transfer, sampled in the setup cycle.
- pready  out  1  transfer completes.
- prdata  out  DATA_WIDTH  read data.
- pslverr  out  1  error response.

## Operation
- Word index: idx = paddr >> log2(DATA_WIDTH/8).
- Misaligned: the low log2(DATA_WIDTH/8) bits of paddr are nonzero.
- Error condition (ERR_EN=True only): idx >= DEPTH, or the address is misaligned.
- FSM states:
  - IDLE: when psel=1 and penable=0 (setup cycle), latch wait_cfg into wcnt and move to ACCESS. Otherwise stay in IDLE.
  - ACCESS: if psel=0, abort to IDLE with no memory update. If wcnt != 0, decrement wcnt and hold pready=0. If wcnt == 0, complete the transfer and return to IDLE.
- Completion cycle (state=ACCESS, wcnt=0, psel=1, penable=1):
  - pready=1.
  - Write without error: on the same clock edge, each lane i with pstrb[i]=1 (or every lane when USE_PSTRB=False) takes pwdata[8i+7:8i] into mem[idx].
  - Read without error: prdata = mem[idx].
  - Any error: pslverr=1, prdata=0, memory unchanged.
- Outputs are combinational from state, wcnt and the current bus inputs. Outside the completion cycle: pready=0, pslverr=0, prdata=0.
- paddr, pwrite, pwdata and pstrb are sampled in the completion cycle. Stability across the transfer is the master's responsibility.
- Memory is flop-based and reset to all zeros.

## Timing
- Reset: state=IDLE, wcnt=0, memory cleared, pready=0, pslverr=0, prdata=0.
- Reset assertion mid-transfer takes effect immediately. No memory update occurs, and after release the FSM waits in IDLE for a new setup cycle.
- Transfer length is 2 + wait_cfg cycles, counted from setup to completion inclusive. Maximum is 17.
- Back-to-back transfers: the cycle after completion is sampled in IDLE, so a new setup there starts the next transfer with no idle gap.
- A write followed immediately by a read of the same address returns the new data.
- penable=1 while in IDLE (protocol violation) is ignored. The FSM stays in IDLE and pready stays 0.
- psel deasserting during wait states aborts the transfer: no write, and pready never pulses.
- wait_cfg changes outside the setup cycle have no effect on the current transfer.

## Test plan
- Reset, then a write of 0xDEADBEEF to 0x0010 with wait_cfg=0, then a read of 0x0010 → the write completes in 2 cycles, and the read returns prdata=0xDEADBEEF with pready=1 and pslverr=0.
- wait_cfg=3 on a read of 0x0004 → pready low for 3 access cycles, high on the 5th cycle. prdata=0 after reset.
- Write 0xFFFFFFFF to 0x0020, then write 0x11223344 with pstrb=4'b0101, then read → 0xFF22FF44. With USE_PSTRB=False the read returns 0x11223344.
- Write to 0x0100 (idx 64 = DEPTH) and to 0x0002 (misaligned) → pslverr=1 with pready=1, prdata=0. A later read of idx 0 returns the prior value, showing memory is untouched.
- psel dropped after 1 of 4 wait states on a write of 0xA5A5A5A5 to 0x0008 → pready never rises, and a later read of 0x0008 returns the old data.
- presetn pulsed low during the ACCESS state of a write, and 8 back-to-back zero-wait writes to incrementing addresses → outputs are 0 and memory is all zeros after reset, and each back-to-back write completes in exactly 2 cycles with correct readback.

Source files
------------

// File: rtl/yuu_common_pkg.sv
// Shared types for the yuu APB components.
package yuu_common_pkg;

    typedef enum bit {
        False = 1'b0,
        True  = 1'b1
    } boolean;

endpackage

// File: rtl/yuu_apb_mem_slave.sv
// APB3/APB4 completer backed by a flop-based word memory, with per-transfer
// programmable wait states, byte-lane strobes and range/alignment errors.
module yuu_apb_mem_slave
    import yuu_common_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 64,
    parameter boolean      USE_PSTRB  = True,
    parameter boolean      ERR_EN     = True
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic [3:0]              wait_cfg,
    output logic                    pready,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pslverr
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              wcnt_q, wcnt_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]   mem_d [DEPTH];

    logic [ADDR_WIDTH-1:0]   idx_full;
    logic [IDX_W-1:0]        idx;
    logic                    misaligned;
    logic                    out_of_range;
    logic                    access_err;

    // Address decode; the modulo only matters when errors are disabled.
    always_comb begin
        idx_full     = paddr >> OFF_W;
        misaligned   = (idx_full << OFF_W) != paddr;
        out_of_range = idx_full >= ADDR_WIDTH'(DEPTH);
        access_err   = (ERR_EN == True) && (misaligned || out_of_range);
        idx          = IDX_W'(idx_full % ADDR_WIDTH'(DEPTH));
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        mem_d   = mem_q;
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;

        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    wcnt_d  = wait_cfg;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    wcnt_d  = '0;
                    state_d = IDLE;
                end else if (wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else if (penable) begin
                    pready  = 1'b1;
                    state_d = IDLE;
                    if (access_err) begin
                        pslverr = 1'b1;
                    end else if (pwrite) begin
                        for (int unsigned i = 0; i < STRB_W; i++) begin
                            if ((USE_PSTRB == False) || pstrb[i]) begin
                                mem_d[idx][8*i +: 8] = pwdata[8*i +: 8];
                            end
                        end
                    end else begin
                        prdata = mem_q[idx];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            mem_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: tb/tb_yuu_apb_mem_slave.sv
// Directed bench for yuu_apb_mem_slave: a strobed instance plus a no-strobe
// instance sharing the same bus inputs.
module tb_yuu_apb_mem_slave;
    import yuu_common_pkg::*;

    logic        pclk;
    logic        presetn;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [3:0]  wait_cfg;
    logic        pready, pready_ns;
    logic [31:0] prdata, prdata_ns;
    logic        pslverr, pslverr_ns;

    int tests;
    int fails;

    logic [31:0] rd, rd_ns;
    logic        err;
    int          cyc;

    yuu_apb_mem_slave #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(64),
        .USE_PSTRB(True), .ERR_EN(True)
    ) dut (
        .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .wait_cfg(wait_cfg), .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    yuu_apb_mem_slave #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(64),
        .USE_PSTRB(False), .ERR_EN(True)
    ) dut_ns (
        .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .wait_cfg(wait_cfg), .pready(pready_ns), .prdata(prdata_ns), .pslverr(pslverr_ns)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required $finish before 200000");
        $fatal(1);
    end

    // One full transfer starting now (just after a rising edge); returns just
    // after the edge that ends the completion cycle, so calls chain back-to-back.
    task automatic xfer(input logic wr, input logic [15:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [3:0] wc);
        logic done;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
        pwdata = data; pstrb = strb; wait_cfg = wc;
        rd = '0; rd_ns = '0; err = 1'b0; done = 1'b0;
        @(negedge pclk); cyc = 1;
        @(posedge pclk); #1;
        penable = 1'b1;
        wait_cfg = ~wc;
        while (!done && cyc < 40) begin
            @(negedge pclk);
            cyc++;
            if (pready) begin
                done = 1'b1; rd = prdata; rd_ns = prdata_ns; err = pslverr;
            end else begin
                @(posedge pclk); #1;
            end
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL xfer_timeout addr=%h: pready never rose within %0d cycles", addr, cyc);
        end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        presetn = 1'b0;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = '0;
        pwdata = '0; pstrb = '0; wait_cfg = '0;
        @(negedge pclk);
        tests++;
        if (pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs: got pready=%b pslverr=%b prdata=%h, required 0/0/0",
                     pready, pslverr, prdata);
        end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; presetn = 1'b1;
        @(posedge pclk); #1;
    endtask

    task automatic test_basic();
        xfer(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 4'd0);
        tests++;
        if (cyc !== 2 || err !== 1'b0) begin
            fails++;
            $display("FAIL basic_write: got cycles=%0d pslverr=%b, required 2/0", cyc, err);
        end
        xfer(1'b0, 16'h0010, 32'h0, 4'h0, 4'd0);
        tests++;
        if (rd !== 32'hDEADBEEF || err !== 1'b0 || cyc !== 2) begin
            fails++;
            $display("FAIL basic_read: got prdata=%h pslverr=%b cycles=%0d, required deadbeef/0/2",
                     rd, err, cyc);
        end
    endtask

    task automatic test_wait_states();
        xfer(1'b0, 16'h0004, 32'h0, 4'h0, 4'd3);
        tests++;
        if (cyc !== 5 || rd !== 32'h0 || err !== 1'b0) begin
            fails++;
            $display("FAIL wait3_read: got cycles=%0d prdata=%h pslverr=%b, required 5/00000000/0",
                     cyc, rd, err);
        end
        xfer(1'b0, 16'h0010, 32'h0, 4'h0, 4'd15);
        tests++;
        if (cyc !== 17 || rd !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL wait15_read: got cycles=%0d prdata=%h, required 17/deadbeef", cyc, rd);
        end
    endtask

    task automatic test_pstrb();
        xfer(1'b1, 16'h0020, 32'hFFFFFFFF, 4'hF, 4'd0);
        xfer(1'b1, 16'h0020, 32'h11223344, 4'b0101, 4'd1);
        xfer(1'b0, 16'h0020, 32'h0, 4'h0, 4'd0);
        tests++;
        if (rd !== 32'hFF22FF44) begin
            fails++;
            $display("FAIL pstrb_merge: got %h, required ff22ff44", rd);
        end
        tests++;
        if (rd_ns !== 32'h11223344) begin
            fails++;
            $display("FAIL pstrb_ignored: got %h, required 11223344", rd_ns);
        end
    endtask

    task automatic test_errors();
        xfer(1'b1, 16'h0000, 32'h0BADF00D, 4'hF, 4'd0);
        xfer(1'b1, 16'h0100, 32'hFFFFFFFF, 4'hF, 4'd0);
        tests++;
        if (err !== 1'b1 || rd !== 32'h0 || cyc !== 2) begin
            fails++;
            $display("FAIL err_range: got pslverr=%b prdata=%h cycles=%0d, required 1/0/2",
                     err, rd, cyc);
        end
        xfer(1'b1, 16'h0002, 32'hFFFFFFFF, 4'hF, 4'd2);
        tests++;
        if (err !== 1'b1 || rd !== 32'h0 || cyc !== 4) begin
            fails++;
            $display("FAIL err_misaligned: got pslverr=%b prdata=%h cycles=%0d, required 1/0/4",
                     err, rd, cyc);
        end
        xfer(1'b0, 16'h0102, 32'h0, 4'h0, 4'd0);
        tests++;
        if (err !== 1'b1 || rd !== 32'h0) begin
            fails++;
            $display("FAIL err_read: got pslverr=%b prdata=%h, required 1/0", err, rd);
        end
        xfer(1'b0, 16'h0000, 32'h0, 4'h0, 4'd0);
        tests++;
        if (err !== 1'b0 || rd !== 32'h0BADF00D) begin
            fails++;
            $display("FAIL err_mem_untouched: got pslverr=%b prdata=%h, required 0/0badf00d",
                     err, rd);
        end
    endtask

    task automatic test_abort();
        logic seen;
        xfer(1'b1, 16'h0008, 32'h12345678, 4'hF, 4'd0);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0008;
        pwdata = 32'hA5A5A5A5; pstrb = 4'hF; wait_cfg = 4'd4;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        seen = pready;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        repeat (6) begin
            @(negedge pclk);
            seen = seen | pready;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL abort_pready: got pready pulse=%b, required 0", seen);
        end
        // penable without a setup cycle must be ignored
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b1; pwdata = 32'hDEAD0000;
        seen = 1'b0;
        repeat (4) begin
            @(negedge pclk);
            seen = seen | pready;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL idle_penable: got pready pulse=%b, required 0", seen);
        end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        xfer(1'b0, 16'h0008, 32'h0, 4'h0, 4'd0);
        tests++;
        if (rd !== 32'h12345678) begin
            fails++;
            $display("FAIL abort_mem: got %h, required 12345678", rd);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0030;
        pwdata = 32'hCAFEF00D; pstrb = 4'hF; wait_cfg = 4'd0;
        @(posedge pclk); #1;
        penable = 1'b1;
        #1;
        tests++;
        if (pready !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_precheck: got pready=%b, required 1", pready);
        end
        presetn = 1'b0;
        #1;
        tests++;
        if (pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 32'h0) begin
            fails++;
            $display("FAIL rstmid_outputs: got pready=%b pslverr=%b prdata=%h, required 0/0/0",
                     pready, pslverr, prdata);
        end
        @(posedge pclk); #1;
        presetn = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(negedge pclk);
            seen = seen | pready;
            @(posedge pclk); #1;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_idle: got pready pulse=%b, required 0", seen);
        end
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        for (int k = 0; k < 64; k++) begin
            xfer(1'b0, 16'(k * 4), 32'h0, 4'h0, 4'd0);
            tests++;
            if (rd !== 32'h0 || err !== 1'b0) begin
                fails++;
                $display("FAIL rstmid_mem[%0d]: got prdata=%h pslverr=%b, required 0/0", k, rd, err);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            xfer(1'b1, 16'(16'h0040 + k * 4), 32'hB2B00000 + 32'(k * 32'h111), 4'hF, 4'd0);
            tests++;
            if (cyc !== 2 || err !== 1'b0) begin
                fails++;
                $display("FAIL b2b_write[%0d]: got cycles=%0d pslverr=%b, required 2/0", k, cyc, err);
            end
        end
        for (int k = 7; k >= 0; k--) begin
            xfer(1'b0, 16'(16'h0040 + k * 4), 32'h0, 4'h0, 4'd0);
            tests++;
            if (rd !== 32'hB2B00000 + 32'(k * 32'h111) || cyc !== 2) begin
                fails++;
                $display("FAIL b2b_read[%0d]: got prdata=%h cycles=%0d, required %h/2",
                         k, rd, cyc, 32'hB2B00000 + 32'(k * 32'h111));
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_wait_states();
        test_pstrb();
        test_errors();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
